// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Index width for a master count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the masters, the arbiter and the shared slave port.
// Handshake: a master owns the slave from the cycle it is granted until its cyc
// drops; within that window each cycle with stb high and s_ack_i high is one beat.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  import wb_arb_pkg::*;

  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS*AW-1:0] m_adr_i;
  logic [NUM_MASTERS*DW-1:0] m_dat_i;
  logic [DW-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [AW-1:0]             s_adr_o;
  logic [DW-1:0]             s_dat_o;
  logic [DW-1:0]             s_dat_i;
  logic                      s_ack_i;
  logic [NUM_MASTERS-1:0]    grant_o;
  logic                      busy_o;
  arb_state_e                state_o;

  // Arbiter view.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o,
           s_dat_o, grant_o, busy_o, state_o
  );

  // Environment view: masters plus the shared slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o,
           s_dat_o, grant_o, busy_o, state_o
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_i,
// wrapping modulo NUM_MASTERS.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          last_i,
  output logic                   valid_o,
  output logic [IW-1:0]          winner_o
);

  int idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    // Offset 1 first, NUM_MASTERS last, so the previous owner has lowest priority.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_i) + i) % NUM_MASTERS;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters,
// with whole-cycle ownership and a per-grant no-ack watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic            clk,
  input  logic            rst,
  wb_rr_arbiter_if.slave  bus
);

  localparam int IW = idx_width(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          own_cyc, own_stb;

  wb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IW         (IW)
  ) u_picker (
    .req_i   (bus.m_cyc_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .winner_o(pick_idx)
  );

  // last_q doubles as the owner index while in OWN or DRAIN.
  assign own_cyc = bus.m_cyc_i[last_q];
  assign own_stb = bus.m_stb_i[last_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d = ST_OWN;
          grant_d = NUM_MASTERS'(1) << pick_idx;
          last_d  = pick_idx;
        end
      end
      ST_OWN: begin
        bus.s_cyc_o          = own_cyc;
        bus.s_stb_o          = own_stb;
        bus.s_we_o           = bus.m_we_i[last_q];
        bus.s_adr_o          = bus.m_adr_i[int'(last_q)*AW +: AW];
        bus.s_dat_o          = bus.m_dat_i[int'(last_q)*DW +: DW];
        bus.m_ack_o[last_q]  = bus.s_ack_i;
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (bus.s_ack_i) begin
          cnt_d = '0;
        end else if ((TIMEOUT > 0) && own_stb && (cnt_q == CNT_MAX)) begin
          // Give up on the slave: error the owner and pull the bus off it.
          bus.m_err_o[last_q] = 1'b1;
          bus.s_cyc_o         = 1'b0;
          bus.s_stb_o         = 1'b0;
          cnt_d               = '0;
          state_d             = ST_DRAIN;
        end else if (own_stb) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant_q;
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a table of per-cycle vectors followed by
// hand-written watchdog and reset sequences.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 2;
  localparam logic [31:0] DAT0 = 32'hA0A0_0000;
  localparam logic [31:0] DAT1 = 32'hB1B1_0000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wb_rr_arbiter_if #(.NUM_MASTERS(NM), .AW(32), .DW(32)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS(NM),
    .AW         (32),
    .DW         (32),
    .TIMEOUT    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr0, adr1;
    logic        ack;
    logic [31:0] sdat;
    logic [1:0]  e_grant, e_ack;
    logic [2:0]  e_ctl;
    logic [31:0] e_sadr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [1:0] cyc, stb, we,
                              input logic [31:0] adr0, adr1, input logic ack,
                              input logic [31:0] sdat, input logic [1:0] e_grant,
                              e_ack, input logic [2:0] e_ctl,
                              input logic [31:0] e_sadr, input logic e_busy);
    vec_t v;
    v.name = name; v.cyc = cyc; v.stb = stb; v.we = we;
    v.adr0 = adr0; v.adr1 = adr1; v.ack = ack; v.sdat = sdat;
    v.e_grant = e_grant; v.e_ack = e_ack; v.e_ctl = e_ctl;
    v.e_sadr = e_sadr; v.e_busy = e_busy;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [1:0] c, s, w,
                      input logic [31:0] a0, a1, input logic k,
                      input logic [31:0] d);
    @(posedge clk);
    #1;
    rst         = r;
    bus.m_cyc_i = c;
    bus.m_stb_i = s;
    bus.m_we_i  = w;
    bus.m_adr_i = {a1, a0};
    bus.m_dat_i = {DAT1, DAT0};
    bus.s_ack_i = k;
    bus.s_dat_i = d;
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sdato(input logic [1:0] g);
    return (g == 2'b01) ? DAT0 : (g == 2'b10) ? DAT1 : 32'h0;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_dat_i = '0;

    // single master read, then two-master rotation, then a burst with a waiting master
    vecs.push_back(mk("rst_state", 2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("s1_req",    2'b01, 2'b01, 2'b00, 32'h100, 32'h0,   0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("s1_wait",   2'b01, 2'b01, 2'b00, 32'h100, 32'h0,   0, 32'h0,        2'b01, 2'b00, 3'b110, 32'h100, 1));
    vecs.push_back(mk("s1_ack",    2'b01, 2'b01, 2'b00, 32'h100, 32'h0,   1, 32'hDEADBEEF, 2'b01, 2'b01, 3'b110, 32'h100, 1));
    vecs.push_back(mk("s1_drop",   2'b00, 2'b00, 2'b00, 32'h100, 32'h0,   0, 32'h0,        2'b01, 2'b00, 3'b000, 32'h100, 1));
    vecs.push_back(mk("s1_idle",   2'b00, 2'b00, 2'b00, 32'h100, 32'h0,   0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("rr_req",    2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("rr_m1",     2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 1, 32'h11,       2'b10, 2'b10, 3'b110, 32'h300, 1));
    vecs.push_back(mk("rr_m1_rel", 2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b10, 2'b00, 3'b000, 32'h300, 1));
    vecs.push_back(mk("rr_dead1",  2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("rr_m0",     2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 1, 32'h22,       2'b01, 2'b01, 3'b110, 32'h200, 1));
    vecs.push_back(mk("rr_m0_rel", 2'b10, 2'b10, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b01, 2'b00, 3'b000, 32'h200, 1));
    vecs.push_back(mk("rr_dead2",  2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("rr_m1b",    2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 1, 32'h33,       2'b10, 2'b10, 3'b110, 32'h300, 1));
    vecs.push_back(mk("rr_m1b_rel",2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b10, 2'b00, 3'b000, 32'h300, 1));
    vecs.push_back(mk("rr_dead3",  2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("rr_m0b",    2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 1, 32'h44,       2'b01, 2'b01, 3'b110, 32'h200, 1));
    vecs.push_back(mk("bu_m0_rel", 2'b10, 2'b10, 2'b10, 32'h200, 32'h10,  0, 32'h0,        2'b01, 2'b00, 3'b000, 32'h200, 1));
    vecs.push_back(mk("bu_arb",    2'b11, 2'b11, 2'b10, 32'h200, 32'h10,  0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("bu_b0",     2'b11, 2'b11, 2'b10, 32'h200, 32'h10,  1, 32'h0,        2'b10, 2'b10, 3'b111, 32'h10,  1));
    vecs.push_back(mk("bu_b1",     2'b11, 2'b11, 2'b10, 32'h200, 32'h11,  1, 32'h0,        2'b10, 2'b10, 3'b111, 32'h11,  1));
    vecs.push_back(mk("bu_wait",   2'b11, 2'b11, 2'b10, 32'h200, 32'h12,  0, 32'h0,        2'b10, 2'b00, 3'b111, 32'h12,  1));
    vecs.push_back(mk("bu_b2",     2'b11, 2'b11, 2'b10, 32'h200, 32'h12,  1, 32'h0,        2'b10, 2'b10, 3'b111, 32'h12,  1));
    vecs.push_back(mk("bu_b3",     2'b11, 2'b11, 2'b10, 32'h200, 32'h13,  1, 32'h0,        2'b10, 2'b10, 3'b111, 32'h13,  1));
    vecs.push_back(mk("bu_rel",    2'b01, 2'b01, 2'b00, 32'h200, 32'h13,  0, 32'h0,        2'b10, 2'b00, 3'b000, 32'h13,  1));
    vecs.push_back(mk("bu_dead",   2'b01, 2'b01, 2'b00, 32'h200, 32'h13,  0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));
    vecs.push_back(mk("bu_m0",     2'b01, 2'b01, 2'b00, 32'h200, 32'h13,  1, 32'h0,        2'b01, 2'b01, 3'b110, 32'h200, 1));
    vecs.push_back(mk("bu_m0_rel", 2'b00, 2'b00, 2'b00, 32'h200, 32'h13,  0, 32'h0,        2'b01, 2'b00, 3'b000, 32'h200, 1));
    vecs.push_back(mk("end_idle",  2'b00, 2'b00, 2'b00, 32'h200, 32'h13,  0, 32'h0,        2'b00, 2'b00, 3'b000, 32'h0,   0));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].adr0, vecs[i].adr1,
           vecs[i].ack, vecs[i].sdat);
      chk({vecs[i].name, ".grant"}, 32'(bus.grant_o), 32'(vecs[i].e_grant));
      chk({vecs[i].name, ".ack"},   32'(bus.m_ack_o), 32'(vecs[i].e_ack));
      chk({vecs[i].name, ".err"},   32'(bus.m_err_o), 32'h0);
      chk({vecs[i].name, ".ctl"},   32'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 32'(vecs[i].e_ctl));
      chk({vecs[i].name, ".sadr"},  bus.s_adr_o, vecs[i].e_sadr);
      chk({vecs[i].name, ".sdato"}, bus.s_dat_o, exp_sdato(vecs[i].e_grant));
      chk({vecs[i].name, ".busy"},  32'(bus.busy_o), 32'(vecs[i].e_busy));
      chk({vecs[i].name, ".mdat"},  bus.m_dat_o, vecs[i].sdat);
    end

    // Watchdog: master 1 wins (last owner was 0), slave never acks.
    step(1'b0, 2'b11, 2'b11, 2'b00, 32'h200, 32'h40, 1'b0, 32'h0);
    chk("to_idle.grant", 32'(bus.grant_o), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 2'b11, 2'b11, 2'b00, 32'h200, 32'h40, 1'b0, 32'h0);
      chk($sformatf("to_stb%0d.err", i),  32'(bus.m_err_o), (i == 8) ? 32'h2 : 32'h0);
      chk($sformatf("to_stb%0d.scyc", i), 32'(bus.s_cyc_o), (i == 8) ? 32'h0 : 32'h1);
      chk($sformatf("to_stb%0d.grant", i), 32'(bus.grant_o), 32'h2);
    end
    for (int i = 0; i < 2; i++) begin
      // A stray slave ack while draining must not reach anyone.
      step(1'b0, 2'b11, 2'b11, 2'b00, 32'h200, 32'h40, 1'b1, 32'h0);
      chk("drain.state", 32'(bus.state_o), 32'(ST_DRAIN));
      chk("drain.ctl",   32'({bus.s_cyc_o, bus.s_stb_o}), 32'h0);
      chk("drain.ack",   32'(bus.m_ack_o), 32'h0);
      chk("drain.err",   32'(bus.m_err_o), 32'h0);
      chk("drain.busy",  32'(bus.busy_o), 32'h1);
    end
    step(1'b0, 2'b01, 2'b01, 2'b00, 32'h200, 32'h40, 1'b0, 32'h0);
    chk("drain_rel.grant", 32'(bus.grant_o), 32'h2);
    step(1'b0, 2'b01, 2'b01, 2'b00, 32'h200, 32'h40, 1'b0, 32'h0);
    chk("drain_dead.grant", 32'(bus.grant_o), 32'h0);
    step(1'b0, 2'b01, 2'b01, 2'b00, 32'h200, 32'h40, 1'b1, 32'h0);
    chk("drain_next.grant", 32'(bus.grant_o), 32'h1);
    chk("drain_next.ack",   32'(bus.m_ack_o), 32'h1);
    step(1'b0, 2'b00, 2'b00, 2'b00, 32'h200, 32'h40, 1'b0, 32'h0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 32'h200, 32'h40, 1'b0, 32'h0);
    chk("drain_end.grant", 32'(bus.grant_o), 32'h0);

    // Ack on the cycle the count reaches TIMEOUT-1: ack wins and the count restarts.
    step(1'b0, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0);
      chk($sformatf("lim_stb%0d.err", i), 32'(bus.m_err_o), 32'h0);
    end
    step(1'b0, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0, 1'b1, 32'hCAFE);
    chk("lim_hit.ack",  32'(bus.m_ack_o), 32'h1);
    chk("lim_hit.err",  32'(bus.m_err_o), 32'h0);
    chk("lim_hit.scyc", 32'(bus.s_cyc_o), 32'h1);
    chk("lim_hit.mdat", bus.m_dat_o, 32'hCAFE);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0);
      chk($sformatf("lim_re%0d.err", i),   32'(bus.m_err_o), 32'h0);
      chk($sformatf("lim_re%0d.state", i), 32'(bus.state_o), 32'(ST_OWN));
    end
    step(1'b0, 2'b00, 2'b00, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0);
    chk("lim_end.grant", 32'(bus.grant_o), 32'h0);

    // One-cycle reset in the middle of a master 1 burst.
    step(1'b0, 2'b10, 2'b10, 2'b10, 32'h200, 32'h50, 1'b0, 32'h0);
    step(1'b0, 2'b11, 2'b11, 2'b10, 32'h200, 32'h50, 1'b1, 32'h0);
    chk("rb_own.grant", 32'(bus.grant_o), 32'h2);
    chk("rb_own.sadr",  bus.s_adr_o, 32'h50);
    step(1'b1, 2'b11, 2'b11, 2'b10, 32'h200, 32'h51, 1'b0, 32'h0);
    step(1'b0, 2'b11, 2'b11, 2'b10, 32'h200, 32'h51, 1'b1, 32'h77);
    chk("rb_post.grant", 32'(bus.grant_o), 32'h0);
    chk("rb_post.ctl",   32'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 32'h0);
    chk("rb_post.sadr",  bus.s_adr_o, 32'h0);
    chk("rb_post.sdato", bus.s_dat_o, 32'h0);
    chk("rb_post.ack",   32'(bus.m_ack_o), 32'h0);
    chk("rb_post.err",   32'(bus.m_err_o), 32'h0);
    chk("rb_post.busy",  32'(bus.busy_o), 32'h0);
    chk("rb_post.mdat",  bus.m_dat_o, 32'h77);
    step(1'b0, 2'b11, 2'b11, 2'b10, 32'h200, 32'h51, 1'b0, 32'h0);
    chk("rb_next.grant", 32'(bus.grant_o), 32'h1);
    chk("rb_next.sadr",  bus.s_adr_o, 32'h200);
    step(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
